ddc_oct_param_bank: RTL

- Sits directly downstream of the DDC AXI-lite register block.
- Consumes the ch/pinc/poff/pvalid write strobe and the software resync, and holds a per-channel shadow table of phase increment and offset.
- On a resync event it sequentially commits every channel to the octal DDS/NCO stage, then issues a single phase-reset pulse.
- Gives software atomic, glitch-free retuning of all channels.

---
 rtl/ddc_oct_param_bank.sv | 112 +++++++++++
 1 files changed

// File: rtl/ddc_oct_param_bank.sv
// ddc_oct_param_bank: per-channel pinc/poff shadow table with atomic, sequential commit to the DDS stage on resync
module ddc_oct_param_bank #(
  parameter  int N_CH  = 8,
  parameter  int ERR_W = 16,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic [31:0]      ch,
  input  logic [31:0]      pinc,
  input  logic [31:0]      poff,
  input  logic             pvalid,
  input  logic             resync_soft,
  input  logic             resync_ext,
  output logic             dds_valid,
  output logic [CH_W-1:0]  dds_ch,
  output logic [31:0]      dds_pinc,
  output logic [31:0]      dds_poff,
  output logic             dds_resync,
  output logic             busy,
  output logic [N_CH-1:0]  dirty,
  output logic [ERR_W-1:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, COMMIT, PULSE} state_t;
  state_t           state_q;
  logic [CH_W-1:0]  idx_q;
  logic             pending_q, pvalid_q, r_q;
  logic [31:0]      pinc_q [N_CH];
  logic [31:0]      poff_q [N_CH];
  logic             valid_q, resync_q, busy_q;
  logic [CH_W-1:0]  ch_q;
  logic [31:0]      opinc_q, opoff_q;
  logic [N_CH-1:0]  dirty_q, dirty_d, clr, set;
  logic [ERR_W-1:0] err_q;
  logic             wr_ev, ch_ok, rs_ev, go;
  logic [CH_W-1:0]  wr_ch;
  always_comb begin
    wr_ev   = pvalid & ~pvalid_q;
    ch_ok   = ch < 32'(N_CH);
    wr_ch   = ch[CH_W-1:0];
    rs_ev   = (resync_soft | resync_ext) & ~r_q;
    go      = rs_ev | pending_q;
    clr     = (state_q == COMMIT) ? (N_CH'(1) << idx_q) : '0;
    set     = (wr_ev && ch_ok) ? (N_CH'(1) << wr_ch) : '0;
    // a write landing on the channel being committed keeps it dirty
    dirty_d = (dirty_q & ~clr) | set;
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      pvalid_q  <= 1'b0;
      r_q       <= 1'b0;
      valid_q   <= 1'b0;
      resync_q  <= 1'b0;
      busy_q    <= 1'b0;
      ch_q      <= '0;
      opinc_q   <= '0;
      opoff_q   <= '0;
      dirty_q   <= '0;
      err_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        pinc_q[i] <= '0;
        poff_q[i] <= '0;
      end
    end else begin
      pvalid_q <= pvalid;
      r_q      <= resync_soft | resync_ext;
      valid_q  <= 1'b0;
      resync_q <= 1'b0;
      busy_q   <= state_q != IDLE;
      dirty_q  <= dirty_d;
      if (wr_ev && ch_ok) begin
        pinc_q[wr_ch] <= pinc;
        poff_q[wr_ch] <= poff;
      end
      if (wr_ev && !ch_ok && err_q != '1) err_q <= err_q + ERR_W'(1);
      case (state_q)
        IDLE: if (go) begin
          state_q   <= COMMIT;
          idx_q     <= '0;
          pending_q <= 1'b0;
        end
        COMMIT: begin
          valid_q <= 1'b1;
          ch_q    <= idx_q;
          opinc_q <= pinc_q[idx_q];
          opoff_q <= poff_q[idx_q];
          idx_q   <= idx_q + CH_W'(1);
          if (idx_q == CH_W'(N_CH - 1)) state_q <= PULSE;
          if (rs_ev) pending_q <= 1'b1;
        end
        PULSE: begin
          resync_q  <= 1'b1;
          state_q   <= go ? COMMIT : IDLE;
          idx_q     <= '0;
          pending_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign dds_valid  = valid_q;
  assign dds_ch     = ch_q;
  assign dds_pinc   = opinc_q;
  assign dds_poff   = opoff_q;
  assign dds_resync = resync_q;
  assign busy       = busy_q;
  assign dirty      = dirty_q;
  assign err_cnt    = err_q;
endmodule
